// File: rtl/lzrw1_stream_unpacker.sv
// Splits an LZRW1 compressed byte stream (control byte + up to 8 two-byte items)
// into (16-bit item, control bit) pairs for decompressor_top, stopping at the 0x0000 terminator.
module lzrw1_stream_unpacker #(
    parameter int unsigned ITEMS_PER_CTRL = 8,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   restart,
    input  logic [7:0]             byte_in,
    input  logic                   byte_in_valid,
    output logic                   byte_in_ready,
    output logic [15:0]            data_out,
    output logic                   control_bit_out,
    output logic                   data_out_valid,
    input  logic                   decompressor_busy,
    output logic                   stream_done,
    output logic [COUNT_WIDTH-1:0] item_count
);

    localparam int unsigned IDX_W = $clog2(ITEMS_PER_CTRL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITEMS_PER_CTRL - 1);

    typedef enum logic [2:0] {
        S_CTRL,
        S_ITEM_HI,
        S_ITEM_LO,
        S_PRESENT,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [ITEMS_PER_CTRL-1:0] ctrl_q, ctrl_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [7:0]                hi_q, hi_d;
    logic [15:0]               data_q, data_d;
    logic                      cbit_q, cbit_d;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;

    logic        byte_xfer;
    logic        item_xfer;
    logic [15:0] item_word;

    // Ready is gated by the reset pin so it reads 0 while reset is held.
    assign byte_in_ready = reset &&
                           ((state_q == S_CTRL) || (state_q == S_ITEM_HI) || (state_q == S_ITEM_LO));
    assign byte_xfer     = byte_in_valid && byte_in_ready;
    assign item_xfer     = valid_q && !decompressor_busy;
    assign item_word     = {hi_q, byte_in};

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        data_d  = data_q;
        cbit_d  = cbit_q;
        valid_d = valid_q;
        done_d  = done_q;
        count_d = count_q;

        // Restart overrides any byte or item transfer in the same cycle.
        if (restart) begin
            state_d = S_CTRL;
            idx_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            count_d = '0;
        end else begin
            case (state_q)
                S_CTRL: begin
                    if (byte_xfer) begin
                        ctrl_d  = byte_in;
                        idx_d   = '0;
                        state_d = S_ITEM_HI;
                    end
                end
                S_ITEM_HI: begin
                    if (byte_xfer) begin
                        hi_d    = byte_in;
                        state_d = S_ITEM_LO;
                    end
                end
                S_ITEM_LO: begin
                    if (byte_xfer) begin
                        if (item_word == 16'h0000) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            data_d  = item_word;
                            cbit_d  = ctrl_q[LAST_IDX - idx_q];
                            valid_d = 1'b1;
                            state_d = S_PRESENT;
                        end
                    end
                end
                S_PRESENT: begin
                    if (item_xfer) begin
                        valid_d = 1'b0;
                        count_d = count_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_CTRL;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_ITEM_HI;
                        end
                    end
                end
                S_DONE: begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
                default: state_d = S_CTRL;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_CTRL;
            ctrl_q  <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            cbit_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            cbit_q  <= cbit_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign data_out        = data_q;
    assign control_bit_out = cbit_q;
    assign data_out_valid  = valid_q;
    assign stream_done     = done_q;
    assign item_count      = count_q;

endmodule

// File: tb/tb_lzrw1_stream_unpacker.sv
// Directed bench for lzrw1_stream_unpacker: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_lzrw1_stream_unpacker;

    logic        clock;
    logic        reset;
    logic        restart;
    logic [7:0]  byte_in;
    logic        byte_in_valid;
    logic        byte_in_ready;
    logic [15:0] data_out;
    logic        control_bit_out;
    logic        data_out_valid;
    logic        decompressor_busy;
    logic        stream_done;
    logic [15:0] item_count;

    int total;
    int bad;
    logic [16:0] got_q[$];
    logic [7:0]  stream_buf [32];

    lzrw1_stream_unpacker #(
        .ITEMS_PER_CTRL(8),
        .COUNT_WIDTH(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .restart(restart),
        .byte_in(byte_in),
        .byte_in_valid(byte_in_valid),
        .byte_in_ready(byte_in_ready),
        .data_out(data_out),
        .control_bit_out(control_bit_out),
        .data_out_valid(data_out_valid),
        .decompressor_busy(decompressor_busy),
        .stream_done(stream_done),
        .item_count(item_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Records every item that will be taken on the next rising edge.
    always @(negedge clock) begin
        if (reset && data_out_valid && !decompressor_busy && !restart)
            got_q.push_back({control_bit_out, data_out});
    end

    task automatic send_byte(input logic [7:0] b);
        bit sent;
        sent = 1'b0;
        byte_in       = b;
        byte_in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (byte_in_ready) begin
                @(posedge clock);
                #1;
                sent = 1'b1;
                break;
            end
        end
        byte_in_valid = 1'b0;
        if (!sent) begin
            total++;
            bad++;
            $display("FAIL send_timeout byte=%h ready=%b required ready=1", b, byte_in_ready);
        end
    endtask

    task automatic send_stream(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_byte(stream_buf[i]);
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clock);
                    #1;
                end
            end
        end
    endtask

    task automatic load_test1;
        stream_buf[0] = 8'h80;
        stream_buf[1] = 8'h12; stream_buf[2] = 8'h34;
        stream_buf[3] = 8'h00; stream_buf[4] = 8'h41;
        stream_buf[5] = 8'h00; stream_buf[6] = 8'h00;
    endtask

    task automatic pulse_restart;
        restart = 1'b1;
        @(posedge clock);
        #1;
        restart = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; restart = 1'b0; byte_in = 8'h00; byte_in_valid = 1'b0;
        decompressor_busy = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({byte_in_ready, data_out_valid, stream_done, control_bit_out} !== 4'b0000
            || data_out !== 16'h0000 || item_count !== 16'h0000) begin
            bad++;
            $display("FAIL reset_hold ready=%b valid=%b done=%b cw=%b data=%h cnt=%0d required all 0",
                     byte_in_ready, data_out_valid, stream_done, control_bit_out, data_out, item_count);
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (byte_in_ready !== 1'b1 || data_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release ready=%b valid=%b required ready=1 valid=0",
                     byte_in_ready, data_out_valid);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic_stream(input bit gaps, input string tag);
        got_q.delete();
        load_test1();
        send_stream(7, gaps);
        total++;
        if (got_q.size() !== 2) begin
            bad++;
            $display("FAIL %s_nitems got=%0d required=2", tag, got_q.size());
        end else begin
            total++;
            if (got_q[0] !== 17'h1_1234) begin
                bad++;
                $display("FAIL %s_item0 got=%h required=%h", tag, got_q[0], 17'h1_1234);
            end
            total++;
            if (got_q[1] !== 17'h0_0041) begin
                bad++;
                $display("FAIL %s_item1 got=%h required=%h", tag, got_q[1], 17'h0_0041);
            end
        end
        total++;
        if (stream_done !== 1'b1 || byte_in_ready !== 1'b0 || data_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_done done=%b ready=%b valid=%b required 1 0 0",
                     tag, stream_done, byte_in_ready, data_out_valid);
        end
        total++;
        if (item_count !== 16'd2) begin
            bad++;
            $display("FAIL %s_count got=%0d required=2", tag, item_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [16:0] exp;
        pulse_restart();
        got_q.delete();
        stream_buf[0] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            stream_buf[1 + 2*i] = 8'(i + 1);
            stream_buf[2 + 2*i] = 8'(i + 1);
        end
        stream_buf[17] = 8'hFF;
        stream_buf[18] = 8'hAB; stream_buf[19] = 8'hCD;
        stream_buf[20] = 8'h00; stream_buf[21] = 8'h00;
        send_stream(22, 1'b0);
        total++;
        if (got_q.size() !== 9) begin
            bad++;
            $display("FAIL b2b_nitems got=%0d required=9", got_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (i < 8) exp = {1'(i % 2), 8'(i + 1), 8'(i + 1)};
                else       exp = 17'h1_ABCD;
                total++;
                if (got_q[i] !== exp) begin
                    bad++;
                    $display("FAIL b2b_item%0d got=%h required=%h", i, got_q[i], exp);
                end
            end
        end
        total++;
        if (item_count !== 16'd9 || stream_done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_end cnt=%0d done=%b required cnt=9 done=1", item_count, stream_done);
        end
    endtask

    task automatic test_busy_hold;
        pulse_restart();
        got_q.delete();
        send_byte(8'h80);
        send_byte(8'h12);
        decompressor_busy = 1'b1;
        send_byte(8'h34);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            total++;
            if (data_out_valid !== 1'b1 || data_out !== 16'h1234 || control_bit_out !== 1'b1
                || byte_in_ready !== 1'b0 || item_count !== 16'd0) begin
                bad++;
                $display("FAIL busy_hold_c%0d valid=%b data=%h cw=%b ready=%b cnt=%0d required 1 1234 1 0 0",
                         c, data_out_valid, data_out, control_bit_out, byte_in_ready, item_count);
            end
        end
        @(posedge clock);
        #1;
        decompressor_busy = 1'b0;
        @(posedge clock);
        #1;
        total++;
        if (data_out_valid !== 1'b0 || item_count !== 16'd1 || got_q.size() !== 1) begin
            bad++;
            $display("FAIL busy_release valid=%b cnt=%0d taken=%0d required 0 1 1",
                     data_out_valid, item_count, got_q.size());
        end
        send_byte(8'h00);
        send_byte(8'h00);
        total++;
        if (stream_done !== 1'b1 || item_count !== 16'd1) begin
            bad++;
            $display("FAIL busy_end done=%b cnt=%0d required 1 1", stream_done, item_count);
        end
    endtask

    task automatic test_async_reset;
        pulse_restart();
        send_byte(8'h80);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({byte_in_ready, data_out_valid, stream_done, control_bit_out} !== 4'b0000
            || data_out !== 16'h0000 || item_count !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset ready=%b valid=%b done=%b cw=%b data=%h cnt=%0d required all 0",
                     byte_in_ready, data_out_valid, stream_done, control_bit_out, data_out, item_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        got_q.delete();
        stream_buf[0] = 8'h00;
        stream_buf[1] = 8'h00; stream_buf[2] = 8'h61;
        stream_buf[3] = 8'h00; stream_buf[4] = 8'h00;
        send_stream(5, 1'b0);
        total++;
        if (got_q.size() !== 1 || got_q[0] !== 17'h0_0061) begin
            bad++;
            $display("FAIL post_reset_item n=%0d item=%h required n=1 item=%h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 17'h0, 17'h0_0061);
        end
        total++;
        if (item_count !== 16'd1 || stream_done !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_end cnt=%0d done=%b required 1 1", item_count, stream_done);
        end
    endtask

    task automatic test_restart_from_done;
        pulse_restart();
        total++;
        if (stream_done !== 1'b0 || item_count !== 16'd0 || byte_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart_clear done=%b cnt=%0d ready=%b required 0 0 1",
                     stream_done, item_count, byte_in_ready);
        end
        test_basic_stream(1'b0, "again");
    endtask

    task automatic test_restart_vs_transfer;
        pulse_restart();
        got_q.delete();
        send_byte(8'h80);
        send_byte(8'h12);
        decompressor_busy = 1'b1;
        send_byte(8'h34);
        decompressor_busy = 1'b0;
        restart = 1'b1;
        @(posedge clock);
        #1;
        restart = 1'b0;
        total++;
        if (item_count !== 16'd0 || data_out_valid !== 1'b0 || byte_in_ready !== 1'b1
            || stream_done !== 1'b0) begin
            bad++;
            $display("FAIL restart_wins cnt=%0d valid=%b ready=%b done=%b required 0 0 1 0",
                     item_count, data_out_valid, byte_in_ready, stream_done);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_stream(1'b0, "basic");
        test_back_to_back();
        test_busy_hold();
        pulse_restart();
        test_basic_stream(1'b1, "gaps");
        test_async_reset();
        test_restart_from_done();
        test_restart_vs_transfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lzrw1_stream_unpacker.md
Name: lzrw1_stream_unpacker

Overview:
Upstream feeder for decompressor_top. Takes a compressed LZRW1 byte stream: one control byte, then up to 8 two-byte items, repeating. Splits the stream into per-item (16-bit data, 1-bit control) pairs and drives them into decompressor_top's data_in, control_word_in and data_in_valid inputs, honouring decompressor_busy. Detects the 0x0000 end-of-stream item and flags completion.

Parameters:
ITEMS_PER_CTRL, 8, number of items governed by one control byte; fixed at 8 (one control bit per item).
COUNT_WIDTH, 16, width of the forwarded-item counter.

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
restart  input  1  single-cycle pulse; leaves DONE and re-arms for a new stream
byte_in  input  8  compressed stream byte
byte_in_valid  input  1  byte_in is valid this cycle
byte_in_ready  output  1  unpacker accepts byte_in this cycle
data_out  output  16  item to decompressor (data_in); first stream byte in [15:8]
control_bit_out  output  1  control bit for data_out (control_word_in); 1 = copy item, 0 = literal item
data_out_valid  output  1  data_out/control_bit_out valid (data_in_valid)
decompressor_busy  input  1  from decompressor_top; when 1, the item is not taken
stream_done  output  1  0x0000 terminator seen; sticky until restart or reset
item_count  output  COUNT_WIDTH  items forwarded since the last restart/reset

Behaviour:
- Reset (reset = 0, async):
  - state = CTRL; byte_in_ready = 0 during reset, 1 in the first cycle after release.
  - data_out = 0; control_bit_out = 0; data_out_valid = 0; stream_done = 0; item_count = 0.
  - Internal ctrl_reg = 0; item_idx = 0.
- Byte transfer occurs on a rising edge with byte_in_valid && byte_in_ready.
- Item transfer occurs on a rising edge with data_out_valid && !decompressor_busy.
- States:
  - CTRL: byte_in_ready = 1. On transfer: ctrl_reg <= byte_in, item_idx <= 0, -> ITEM_HI.
  - ITEM_HI: byte_in_ready = 1. On transfer: hi_reg <= byte_in, -> ITEM_LO.
  - ITEM_LO: byte_in_ready = 1. On transfer:
    - If {hi_reg, byte_in} == 0x0000: -> DONE; stream_done <= 1; nothing forwarded.
    - Else: data_out <= {hi_reg, byte_in}; control_bit_out <= ctrl_reg[7 - item_idx]; data_out_valid <= 1; -> PRESENT.
  - PRESENT: byte_in_ready = 0; outputs held stable. On item transfer:
    - data_out_valid <= 0; item_count += 1 (wraps modulo 2^COUNT_WIDTH).
    - If item_idx == 7: -> CTRL. Else: item_idx += 1, -> ITEM_HI.
  - DONE: byte_in_ready = 0; data_out_valid = 0; stream_done = 1. On restart: stream_done <= 0, item_count <= 0, -> CTRL.
- Control bit order: the MSB of the control byte governs the first item.
- Latency: data_out_valid rises on the edge that accepts the low byte. Minimum 3 cycles per item: lo byte, accept, next hi byte. Control bytes add 1 cycle per 8 items.
- Handshake:
  - data_out_valid, once high, never drops before the item transfer.
  - decompressor_busy high holds PRESENT indefinitely.
- restart outside DONE: aborts the current stream. Clears data_out_valid, item_count and stream_done; -> CTRL. Any partial item is discarded.
- restart and item transfer in the same cycle: restart wins; item_count = 0.
- byte_in_valid while byte_in_ready = 0: ignored; the upstream source must hold the byte.
- A control byte of 0x00 followed by items is legal (all literals).
- Async reset mid-item: all state cleared immediately; no partial output.

Test Plan:
1. Bytes 0x80, 0x12,0x34, 0x00,0x41, 0x00,0x00, busy = 0 -> items (0x1234, cw 1) and (0x0041, cw 0); stream_done = 1; item_count = 2; byte_in_ready = 0.
2. Control byte 0x55, then 8 items 0x0101..0x0808, then control byte 0xFF, item 0xABCD, then 0x0000 -> control bits 0,1,0,1,0,1,0,1 then 1; item_count = 9.
3. busy held high 5 cycles while presenting 0x1234 -> data_out/valid stable all 5 cycles; byte_in_ready = 0; single transfer when busy drops; item_count increments once.
4. byte_in_valid toggled randomly with gaps during test 1 stream -> identical item sequence and count.
5. Async reset asserted while in ITEM_LO -> all outputs 0 immediately; after release, fresh stream 0x00, 0x00,0x61, 0x00,0x00 -> one item 0x0061, cw 0.
6. In DONE, pulse restart, then send the test-1 stream again -> stream_done clears on restart, reasserts at the end; item_count restarts from 0 and ends at 2.
